// File: rtl/ppg_fixed_pkg.sv
// Shared sign-magnitude fixed-point definitions for the coordinate-descent stages.
// CALC_RHO_SAT_EN selects saturating arithmetic (default: wrap, no overflow flag).
package ppg_fixed_pkg;
  localparam int Q_DEF = 15;
  localparam int N_DEF = 32;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

  localparam logic [N_DEF-2:0] SM_MAX_MAG = '1;
  localparam logic [N_DEF-1:0] SM_ZERO    = '0;

`ifdef CALC_RHO_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif
endpackage

// File: rtl/calc_rho_qmult.sv
// Sign-magnitude Q-format multiplier: full-width magnitude product, truncated >> Q.
// Saturates and flags overflow only when CALC_RHO_SAT_EN is defined.
module qmult
  import ppg_fixed_pkg::*;
#(
  parameter int Q = Q_DEF,
  parameter int N = N_DEF
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_p,
  output logic         o_ovf
);
  localparam int MW = N - 1;

  logic [2*MW-1:0] w_full;
  logic [2*MW-1:0] w_shr;
  logic [MW-1:0]   w_mag;
  logic            w_big;

  assign w_full = {{MW{1'b0}}, i_a[MW-1:0]} * {{MW{1'b0}}, i_b[MW-1:0]};
  assign w_shr  = w_full >> Q;
  assign w_big  = |w_shr[2*MW-1:MW];

  // Without saturation the high bits simply fall off (wrap to N-1 bits).
  assign w_mag  = (SAT_EN && w_big) ? '1 : w_shr[MW-1:0];
  assign o_ovf  = SAT_EN & w_big;
  assign o_p    = {(i_a[N-1] ^ i_b[N-1]) & (|w_mag), w_mag};
endmodule

// File: rtl/calc_rho.sv
// rho_j = A_norm2*xhat_j + sum_i A[i][j]*r[i], streamed from external memories.
// CALC_RHO_SAT_EN enables saturating mult/add and the sticky overflow flag.
module calc_rho
  import ppg_fixed_pkg::*;
#(
  parameter int Q      = Q_DEF,
  parameter int N      = N_DEF,
  parameter int M      = 64,
  parameter int ADDR_W = (M > 1) ? $clog2(M) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [N-1:0]      xhat_j,
  input  logic [N-1:0]      A_norm2,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [N-1:0]      a_data,
  input  logic [N-1:0]      r_data,
  output logic [N-1:0]      rho,
  output logic              ready,
  output logic              busy,
  output logic              overflow
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(M - 1);

  state_e            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [2:1]        r_vld_pipe;
  logic [N-1:0]      r_prod, r_acc, r_rho;
  logic              r_ovf;

  logic [N-1:0]      w_init_p, w_strm_p, w_acc_nxt;
  logic              w_init_ovf, w_strm_ovf, w_add_big;
  logic              w_accept, w_last;

  logic [N-2:0]      w_ma, w_mb, w_mag;
  logic [N-1:0]      w_sum;
  logic              w_sa, w_sb, w_sgn;

  qmult #(.Q(Q), .N(N)) u_init (
    .i_a   (A_norm2),
    .i_b   (xhat_j),
    .o_p   (w_init_p),
    .o_ovf (w_init_ovf)
  );

  qmult #(.Q(Q), .N(N)) u_strm (
    .i_a   (a_data),
    .i_b   (r_data),
    .o_p   (w_strm_p),
    .o_ovf (w_strm_ovf)
  );

  assign w_accept = (r_state == IDLE) && start;
  assign w_last   = (r_addr == LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = READ;
      READ:    if (w_last) w_state_nxt = DRAIN;
      // Last product has just been registered and is being accumulated this edge.
      DRAIN:   if (r_vld_pipe == 2'b10) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Sign-magnitude accumulate; a zero magnitude is always treated as +0.
  always_comb begin
    w_ma  = r_acc[N-2:0];
    w_mb  = r_prod[N-2:0];
    w_sa  = r_acc[N-1] & (|w_ma);
    w_sb  = r_prod[N-1] & (|w_mb);
    w_sgn = w_sa;
    w_sum = '0;
    if (w_sa == w_sb) begin
      w_sum = {1'b0, w_ma} + {1'b0, w_mb};
    end else if (w_ma >= w_mb) begin
      w_sum = {1'b0, w_ma - w_mb};
    end else begin
      w_sum = {1'b0, w_mb - w_ma};
      w_sgn = w_sb;
    end
    w_add_big = w_sum[N-1];
    w_mag     = (SAT_EN && w_add_big) ? '1 : w_sum[N-2:0];
    w_acc_nxt = {w_sgn & (|w_mag), w_mag};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_vld_pipe <= '0;
      r_prod     <= '0;
      r_acc      <= '0;
      r_rho      <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_vld_pipe <= {r_vld_pipe[1], rd_en};
      if (r_vld_pipe[1]) r_prod <= w_strm_p;
      if (w_accept) begin
        r_acc  <= w_init_p;
        r_addr <= '0;
        r_ovf  <= w_init_ovf;
      end else begin
        if (rd_en) r_addr <= w_last ? '0 : r_addr + ADDR_W'(1);
        if (r_vld_pipe[2]) r_acc <= w_acc_nxt;
        r_ovf <= r_ovf | (r_vld_pipe[1] & w_strm_ovf)
                       | (r_vld_pipe[2] & w_add_big & SAT_EN);
      end
      if (r_state == DRAIN && w_state_nxt == DONE) r_rho <= w_acc_nxt;
    end
  end

  assign rd_en    = (r_state == READ);
  assign rd_addr  = r_addr;
  assign busy     = (r_state != IDLE);
  assign ready    = (r_state == DONE);
  assign rho      = r_rho;
  assign overflow = SAT_EN & r_ovf;
endmodule

// File: tb/tb_calc_rho.sv
// Self-checking bench for calc_rho (M=4) against an integer-arithmetic reference model.
// Honours CALC_RHO_SAT_EN for the expected saturation/wrap behaviour.
module tb_calc_rho;
  localparam int Q  = 15;
  localparam int N  = 32;
  localparam int M  = 4;
  localparam int AW = 2;
  localparam longint MAXM = (64'sd1 <<< 31) - 1;

  logic          clk = 1'b0;
  logic          rst_n, start;
  logic [N-1:0]  xhat_j, A_norm2, a_data, r_data, rho;
  logic          rd_en, ready, busy, overflow;
  logic [AW-1:0] rd_addr;

  calc_rho #(.Q(Q), .N(N), .M(M), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .xhat_j(xhat_j), .A_norm2(A_norm2),
    .rd_en(rd_en), .rd_addr(rd_addr), .a_data(a_data), .r_data(r_data),
    .rho(rho), .ready(ready), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  logic [N-1:0] mem_a [M];
  logic [N-1:0] mem_r [M];

  // Memories: one-cycle read latency, junk on the bus when not reading.
  always @(posedge clk) begin
    if (rd_en) begin
      a_data <= mem_a[rd_addr];
      r_data <= mem_r[rd_addr];
    end else begin
      a_data <= $urandom;
      r_data <= $urandom;
    end
  end

  int n_run = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: plain signed integers, converted back to sign-magnitude.
  bit m_ovf;

  function automatic longint val(input logic [31:0] x);
    longint m = longint'(x[30:0]);
    return x[31] ? -m : m;
  endfunction

  function automatic logic [31:0] to_sm(input longint v);
    longint mag = (v < 0) ? -v : v;
    if (mag > MAXM) begin
`ifdef CALC_RHO_SAT_EN
      mag = MAXM;
      m_ovf = 1'b1;
`else
      mag = mag % (MAXM + 1);
`endif
    end
    return {(v < 0) && (mag != 0), mag[30:0]};
  endfunction

  function automatic logic [31:0] mmul(input logic [31:0] a, input logic [31:0] b);
    longint p = (longint'(a[30:0]) * longint'(b[30:0])) >> Q;
    return to_sm((a[31] ^ b[31]) ? -p : p);
  endfunction

  function automatic logic [31:0] madd(input logic [31:0] a, input logic [31:0] b);
    return to_sm(val(a) + val(b));
  endfunction

  // Call at a negedge; start is raised for this cycle (cycle 0). Returns at the
  // negedge of cycle M+4 (IDLE) with start low.
  task automatic run_job(input string tag, input logic [31:0] xh, input logic [31:0] an,
                         input bit hold, output logic [31:0] got);
    logic [31:0] acc;
    bit ovf0;
    m_ovf = 1'b0;
    acc   = mmul(an, xh);
    ovf0  = m_ovf;
    for (int i = 0; i < M; i++) acc = madd(acc, mmul(mem_a[i], mem_r[i]));
    start = 1'b1; xhat_j = xh; A_norm2 = an;
    for (int c = 1; c <= M + 3; c++) begin
      @(negedge clk);
      chk($sformatf("%s rd_en c%0d", tag, c), 32'(rd_en), 32'(c <= M));
      if (c <= M) chk($sformatf("%s rd_addr c%0d", tag, c), 32'(rd_addr), 32'(c - 1));
      chk($sformatf("%s busy c%0d", tag, c), 32'(busy), 32'd1);
      chk($sformatf("%s ready c%0d", tag, c), 32'(ready), 32'(c == M + 3));
      if (c == 1) chk($sformatf("%s ovf_clear", tag), 32'(overflow), 32'(ovf0));
      start = hold; xhat_j = $urandom; A_norm2 = $urandom;
    end
    chk($sformatf("%s rho", tag), rho, acc);
    chk($sformatf("%s overflow", tag), 32'(overflow), 32'(m_ovf));
    got = rho;
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("%s idle busy", tag), 32'(busy), 32'd0);
    chk($sformatf("%s idle ready", tag), 32'(ready), 32'd0);
    chk($sformatf("%s rho hold", tag), rho, acc);
    chk($sformatf("%s ovf hold", tag), 32'(overflow), 32'(m_ovf));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " rho"}, rho, 32'd0);
    chk({tag, " ready"}, 32'(ready), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " overflow"}, 32'(overflow), 32'd0);
    chk({tag, " rd_en"}, 32'(rd_en), 32'd0);
    chk({tag, " rd_addr"}, 32'(rd_addr), 32'd0);
  endtask

  task automatic fill(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                      input logic [31:0] a3, input logic [31:0] rv);
    mem_a[0] = a0; mem_a[1] = a1; mem_a[2] = a2; mem_a[3] = a3;
    for (int i = 0; i < M; i++) mem_r[i] = rv;
  endtask

  logic [31:0] got;
  bit rdy_seen;

  initial begin
    rst_n = 1'b1; start = 1'b0; xhat_j = '0; A_norm2 = '0;
    for (int i = 0; i < M; i++) begin mem_a[i] = '0; mem_r[i] = '0; end
    #2 rst_n = 1'b0;
    start = 1'b1; xhat_j = $urandom; A_norm2 = $urandom;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset busy", 32'(busy), 32'd0);
    chk("post-reset rd_en", 32'(rd_en), 32'd0);

    // Directed: basic, then back-to-back sign cases.
    fill(32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0000_4000);
    run_job("basic", 32'h0, 32'h0002_0000, 1'b0, got);
    chk("basic const", got, 32'h0001_0000);
    fill(32'h0000_8000, 32'h8000_8000, 32'h0000_8000, 32'h8000_8000, 32'h0000_4000);
    run_job("signs1", 32'h8000_2000, 32'h0000_8000, 1'b0, got);
    chk("signs1 const", got, 32'h8000_2000);
    fill(32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h8000_4000);
    run_job("signs2", 32'h0, 32'h0000_8000, 1'b0, got);
    chk("signs2 const", got, 32'h8001_0000);

    // Saturation / wrap, followed by a clean job that must clear overflow.
    fill(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    run_job("sat", 32'h0, 32'h0, 1'b0, got);
`ifdef CALC_RHO_SAT_EN
    chk("sat const", got, 32'h7FFF_FFFF);
    chk("sat ovf set", 32'(overflow), 32'd1);
`else
    chk("wrap const", got, 32'h7FF8_0000);
    chk("wrap ovf tied", 32'(overflow), 32'd0);
`endif
    fill(32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0000_4000);
    run_job("after_sat", 32'h0, 32'h0002_0000, 1'b0, got);

    // Handshake: start held through the ready cycle -> one job only.
    run_job("hold", 32'h0000_4000, 32'h0000_8000, 1'b1, got);
    @(negedge clk);
    chk("hold no 2nd busy", 32'(busy), 32'd0);
    chk("hold no 2nd rd_en", 32'(rd_en), 32'd0);
    run_job("relaunch", 32'h8000_4000, 32'h0001_0000, 1'b0, got);

    // Abort mid-job with reset.
    for (int i = 0; i < M; i++) begin
      mem_a[i] = $urandom & 32'h8001_FFFF; mem_r[i] = $urandom & 32'h8001_FFFF;
    end
    start = 1'b1; xhat_j = 32'h0000_8000; A_norm2 = 32'h0000_8000;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk_zero("abort");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    rdy_seen = 1'b0;
    repeat (M + 4) begin
      @(negedge clk);
      if (ready || busy) rdy_seen = 1'b1;
    end
    chk("abort no ready", 32'(rdy_seen), 32'd0);
    run_job("post_abort", 32'h0000_8000, 32'h0000_8000, 1'b0, got);

    // Randomized jobs, mostly in-range with a few full-range ones.
    for (int j = 0; j < 8; j++) begin
      logic [31:0] msk;
      msk = (j >= 6) ? 32'hFFFF_FFFF : 32'h8001_FFFF;
      for (int i = 0; i < M; i++) begin
        mem_a[i] = $urandom & msk; mem_r[i] = $urandom & msk;
      end
      run_job($sformatf("rand%0d", j), $urandom & msk, $urandom & msk, 1'b0, got);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
